// File: rtl/cu_pkg.sv
// Shared types for the compute-unit address/control sequencer.
package cu_pkg;

  localparam int unsigned SYS_DIM_DEF = 16;

  typedef enum logic [1:0] {
    MODE_INF = 2'd0,
    MODE_FW  = 2'd1,
    MODE_BW  = 2'd2,
    MODE_WU  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic al_we;
    logic zl_we;
    logic dl_we;
    logic w_we;
    logic en_act;
    logic en_actd;
    logic en_wu;
  } wr_en_t;

  // Write-side enables a job of the given mode drives for each result vector.
  function automatic wr_en_t mode_enables(mode_e m);
    wr_en_t e;
    e = '0;
    case (m)
      MODE_INF: begin e.al_we = 1'b1; e.en_act  = 1'b1; end
      MODE_FW:  begin e.zl_we = 1'b1; e.al_we   = 1'b1; e.en_act = 1'b1; end
      MODE_BW:  begin e.dl_we = 1'b1; e.en_actd = 1'b1; end
      MODE_WU:  begin e.w_we  = 1'b1; e.en_wu   = 1'b1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Scheduler/buffer-side signal bundle of the compute-unit sequencer.
interface cu_sequencer_if #(
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned STREAM_W    = 10,
  parameter int unsigned W_ADDR_W    = 8,
  parameter int unsigned AL_ADDR_W   = 11,
  parameter int unsigned DLZL_ADDR_W = 14
);
  logic                   start;
  logic                   abort;
  logic [1:0]             cfg_mode;
  logic [TILE_W-1:0]      cfg_tiles;
  logic [STREAM_W-1:0]    cfg_stream;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;
  logic [1:0]             sel1;
  logic [1:0]             sel2;
  logic                   rd_en;
  logic [W_ADDR_W-1:0]    w_rd_addr;
  logic [AL_ADDR_W-1:0]   al_rd_addr;
  logic [DLZL_ADDR_W-1:0] dlzl_rd_addr;
  logic [DLZL_ADDR_W-1:0] wr_addr;
  logic                   al_we;
  logic                   zl_we;
  logic                   dl_we;
  logic                   w_we;
  logic                   en_act;
  logic                   en_actd;
  logic                   en_wu;

  modport master (
    output start, abort, cfg_mode, cfg_tiles, cfg_stream,
    input  busy, done, cfg_err, sel1, sel2, rd_en, w_rd_addr, al_rd_addr,
           dlzl_rd_addr, wr_addr, al_we, zl_we, dl_we, w_we, en_act, en_actd, en_wu
  );

  modport slave (
    input  start, abort, cfg_mode, cfg_tiles, cfg_stream,
    output busy, done, cfg_err, sel1, sel2, rd_en, w_rd_addr, al_rd_addr,
           dlzl_rd_addr, wr_addr, al_we, zl_we, dl_we, w_we, en_act, en_actd, en_wu
  );
endinterface

// File: rtl/cu_delay_line.sv
// Fixed-depth shift register aligning read-issue strobes with result validity.
module cu_delay_line #(
  parameter int unsigned DEPTH = 31,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one stage per cycle; clear flushes all in-flight bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/cu_sequencer.sv
// Per-job address/control sequencer: issues buffer reads, then raises
// latency-aligned write enables and addresses for the result stream.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned SYS_DIM     = SYS_DIM_DEF,
  parameter int unsigned W_ADDR_W    = 8,
  parameter int unsigned AL_ADDR_W   = 11,
  parameter int unsigned DLZL_ADDR_W = 14,
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned STREAM_W    = 10,
  parameter int unsigned PIPE_LAT    = 2 * SYS_DIM - 1
) (
  input logic          clk,
  input logic          rst,
  cu_sequencer_if.slave bus
);
  localparam int unsigned PW = TILE_W + STREAM_W + AL_ADDR_W + 1;
  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  state_e                 r_state, w_next;
  mode_e                  r_mode;
  logic [TILE_W-1:0]      r_tiles, r_t;
  logic [STREAM_W-1:0]    r_stream, r_k;
  logic [DLZL_ADDR_W-1:0] r_n, r_wr_cnt;
  logic [DW-1:0]          r_drain;
  logic                   r_cfg_err;

  logic                   w_accept, w_abort, w_zero, w_ovf, w_k_last, w_last_issue, w_drain_end;
  logic                   w_rd_en, w_busy, w_done, w_wv;
  logic [1:0]             w_sel;
  logic [PW-1:0]          w_prod;
  wr_en_t                 w_en_issue, w_en_wr;
  logic [7:0]             w_dly_q;

  assign w_accept     = (r_state == ST_IDLE) && bus.start;
  assign w_abort      = (r_state != ST_IDLE) && bus.abort;
  assign w_zero       = (bus.cfg_tiles == '0) || (bus.cfg_stream == '0);
  assign w_prod       = PW'(bus.cfg_tiles) * PW'(bus.cfg_stream);
  assign w_ovf        = w_prod > (PW'(1) << AL_ADDR_W);
  assign w_k_last     = (r_k == r_stream - STREAM_W'(1));
  assign w_last_issue = w_k_last && (r_t == r_tiles - TILE_W'(1));
  assign w_drain_end  = (r_drain == DW'(PIPE_LAT - 1));

  // Next state and state-decoded outputs.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_sel   = r_mode;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_sel  = 2'd0;
        if (bus.start) w_next = w_zero ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        w_rd_en = 1'b1;
        if (w_last_issue) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (w_drain_end) w_next = ST_DONE;
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Job config latch and issue/drain/write counters; counters return to 0
  // on abort and in DONE so the idle addresses read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode    <= MODE_INF;
      r_tiles   <= '0;
      r_stream  <= '0;
      r_cfg_err <= 1'b0;
      r_k       <= '0;
      r_t       <= '0;
      r_n       <= '0;
      r_drain   <= '0;
      r_wr_cnt  <= '0;
    end else if (w_abort || r_state == ST_DONE) begin
      r_k      <= '0;
      r_t      <= '0;
      r_n      <= '0;
      r_drain  <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mode    <= mode_e'(bus.cfg_mode);
        r_tiles   <= bus.cfg_tiles;
        r_stream  <= bus.cfg_stream;
        r_cfg_err <= w_ovf;
        r_k       <= '0;
        r_t       <= '0;
        r_n       <= '0;
        r_drain   <= '0;
        r_wr_cnt  <= '0;
      end
      if (w_rd_en) begin
        r_n <= r_n + DLZL_ADDR_W'(1);
        if (w_k_last) begin
          r_k <= '0;
          r_t <= r_t + TILE_W'(1);
        end else begin
          r_k <= r_k + STREAM_W'(1);
        end
      end
      if (r_state == ST_DRAIN) r_drain <= r_drain + DW'(1);
      if (w_wv) r_wr_cnt <= r_wr_cnt + DLZL_ADDR_W'(1);
    end
  end

  // Mode enables are formed at issue time and travel with the strobe, so
  // they arrive already aligned with their result vector.
  assign w_en_issue = w_rd_en ? mode_enables(r_mode) : '0;

  cu_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (8)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_abort),
    .i_d   ({w_rd_en, w_en_issue}),
    .o_q   (w_dly_q)
  );

  assign w_wv    = w_dly_q[7];
  assign w_en_wr = w_dly_q[6:0];

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.cfg_err      = r_cfg_err;
  assign bus.sel1         = w_sel;
  assign bus.sel2         = w_sel;
  assign bus.rd_en        = w_rd_en;
  assign bus.w_rd_addr    = W_ADDR_W'(r_k);
  assign bus.al_rd_addr   = AL_ADDR_W'(r_n);
  assign bus.dlzl_rd_addr = r_n;
  assign bus.wr_addr      = r_wr_cnt;
  assign bus.al_we        = w_en_wr.al_we;
  assign bus.zl_we        = w_en_wr.zl_we;
  assign bus.dl_we        = w_en_wr.dl_we;
  assign bus.w_we         = w_en_wr.w_we;
  assign bus.en_act       = w_en_wr.en_act;
  assign bus.en_actd      = w_en_wr.en_actd;
  assign bus.en_wu        = w_en_wr.en_wu;
endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: two instances (default al width and a 4-bit al
// width) share stimulus and are compared cycle by cycle with a job model.
module tb_cu_sequencer;
  localparam int LAT = 31;
  localparam int AL0 = 11;
  localparam int AL1 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] tiles = 8'd0;
  logic [9:0] stream = 10'd0;

  int checks = 0;
  int errors = 0;
  bit e_err0 = 1'b0;
  bit e_err1 = 1'b0;

  cu_sequencer_if #(.AL_ADDR_W(AL0)) bus0 ();
  cu_sequencer_if #(.AL_ADDR_W(AL1)) bus1 ();

  assign bus0.start = start;  assign bus1.start = start;
  assign bus0.abort = abort;  assign bus1.abort = abort;
  assign bus0.cfg_mode = mode;  assign bus1.cfg_mode = mode;
  assign bus0.cfg_tiles = tiles;  assign bus1.cfg_tiles = tiles;
  assign bus0.cfg_stream = stream;  assign bus1.cfg_stream = stream;

  cu_sequencer #(.AL_ADDR_W(AL0)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0.slave));
  cu_sequencer #(.AL_ADDR_W(AL1)) dut1 (.clk(clk), .rst(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit order: al, zl, dl, w, act, actd, wu.
  function automatic logic [6:0] exp_en(input int m);
    case (m)
      0:       return 7'b100_0100;
      1:       return 7'b110_0100;
      2:       return 7'b001_0010;
      default: return 7'b000_1001;
    endcase
  endfunction

  task automatic check_outputs(input string ph, input bit busy, input bit done, input bit rd,
                               input int k, input int n, input bit wv, input int wa, input int m);
    logic [1:0] sel;
    sel = busy ? 2'(m) : 2'd0;
    chk({ph, ":busy"}, {bus0.busy, bus1.busy}, {2{busy}});
    chk({ph, ":done"}, {bus0.done, bus1.done}, {2{done}});
    chk({ph, ":rd_en"}, {bus0.rd_en, bus1.rd_en}, {2{rd}});
    chk({ph, ":sel"}, {bus0.sel1, bus0.sel2, bus1.sel1, bus1.sel2}, {4{sel}});
    chk({ph, ":cfg_err"}, {bus0.cfg_err, bus1.cfg_err}, {e_err0, e_err1});
    chk({ph, ":we"},
        {bus0.al_we, bus0.zl_we, bus0.dl_we, bus0.w_we, bus0.en_act, bus0.en_actd, bus0.en_wu,
         bus1.al_we, bus1.zl_we, bus1.dl_we, bus1.w_we, bus1.en_act, bus1.en_actd, bus1.en_wu},
        {2{wv ? exp_en(m) : 7'd0}});
    if (rd) begin
      chk({ph, ":w_rd_addr"}, {bus0.w_rd_addr, bus1.w_rd_addr}, {2{8'(k)}});
      chk({ph, ":dlzl_rd_addr"}, {bus0.dlzl_rd_addr, bus1.dlzl_rd_addr}, {2{14'(n)}});
      chk({ph, ":al_rd_addr0"}, bus0.al_rd_addr, 32'(n % (1 << AL0)));
      chk({ph, ":al_rd_addr1"}, bus1.al_rd_addr, 32'(n % (1 << AL1)));
    end
    if (wv) chk({ph, ":wr_addr"}, {bus0.wr_addr, bus1.wr_addr}, {2{14'(wa)}});
  endtask

  // One job from idle: r counts cycles after the accepting edge. Optional abort
  // at cycle abort_at, ignored restart at cycle restart_at, abort with start.
  task automatic run_job(input string ph, input int m, input int ti, input int st,
                         input int abort_at, input int restart_at, input bit abort_also);
    int n_tot;
    int done_r;
    bit zero;
    bit aborted;
    n_tot   = ti * st;
    zero    = (n_tot == 0);
    done_r  = zero ? 1 : n_tot + LAT + 1;
    aborted = 1'b0;
    mode   = 2'(m);
    tiles  = 8'(ti);
    stream = 10'(st);
    start  = 1'b1;
    abort  = abort_also;
    e_err0 = (n_tot > (1 << AL0));
    e_err1 = (n_tot > (1 << AL1));
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int r = 1; r <= done_r + 1; r++) begin
      if (aborted) begin
        check_outputs(ph, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, m);
      end else begin
        bit e_busy, e_done, e_rd, e_wv;
        int k;
        e_busy = (r <= done_r);
        e_done = (r == done_r);
        e_rd   = !zero && (r <= n_tot);
        e_wv   = !zero && (r >= LAT + 1) && (r <= LAT + n_tot);
        k      = (st > 0) ? (r - 1) % st : 0;
        check_outputs(ph, e_busy, e_done, e_rd, k, r - 1, e_wv, r - LAT - 1, m);
      end
      if (r == abort_at) abort = 1'b1;
      if (r == restart_at && !aborted) begin
        start  = 1'b1;
        mode   = ~2'(m);
        tiles  = 8'(ti + 1);
        stream = 10'(st + 2);
      end
      @(posedge clk); #1;
      if (abort) aborted = 1'b1;
      abort  = 1'b0;
      start  = 1'b0;
      mode   = 2'(m);
      tiles  = 8'(ti);
      stream = 10'(st);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("reset:addr", {bus0.wr_addr, bus0.al_rd_addr, bus0.w_rd_addr, bus1.dlzl_rd_addr}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job("fw_2x4", 1, 2, 4, 0, 0, 1'b0);
    run_job("bw_1x3", 2, 1, 3, 0, 0, 1'b0);
    run_job("zero_tiles", 3, 0, 5, 0, 0, 1'b0);
    run_job("zero_stream", 1, 3, 0, 0, 0, 1'b0);
    run_job("abort_5of8", 1, 2, 4, 5, 0, 1'b0);
    run_job("after_abort", 0, 1, 2, 0, 0, 1'b0);
    run_job("restart_stream", 0, 2, 3, 3, 0, 1'b0);
    run_job("restart_drain", 0, 2, 3, 0, 20, 1'b0);
    run_job("restart_done", 3, 1, 1, 0, LAT + 2, 1'b0);
    run_job("start_abort", 3, 2, 2, 0, 0, 1'b1);
    run_job("abort_drain", 0, 1, 2, 10, 0, 1'b0);
    run_job("al_wrap", 1, 3, 8, 0, 0, 1'b0);
    run_job("clear_err", 2, 1, 1, 0, 0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      int m, ti, st, sel, ab, rs, dr;
      m  = int'($urandom_range(0, 3));
      ti = int'($urandom_range(0, 4));
      st = int'($urandom_range(0, 7));
      dr = (ti * st == 0) ? 1 : ti * st + LAT + 1;
      sel = int'($urandom_range(0, 4));
      ab = (sel == 0) ? int'($urandom_range(1, dr)) : 0;
      rs = (sel == 1) ? int'($urandom_range(1, dr)) : 0;
      run_job("rand", m, ti, st, ab, rs, 1'b0);
    end

    mode = 2'd1; tiles = 8'd2; stream = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    e_err0 = 1'b0;
    e_err1 = 1'b0;
    #1;
    check_outputs("rst_mid", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("rst_mid:addr", {bus0.wr_addr, bus0.al_rd_addr, bus0.w_rd_addr, bus1.dlzl_rd_addr}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("rst_release", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    run_job("after_reset", 1, 2, 4, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
